// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared constants and helpers for the 8x8 average-pool datapath.
//   DATA_W    : default width of one activation sample
//   WIN_SIZE  : default samples per window (8x8)
//   IDX_W     : width of a sample index within a window
//   flat_lsb  : bit offset of sample k inside a flattened window bus
// ---------------------------------------------------------------------------
package pool_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned WIN_SIZE = 64;
    localparam int unsigned IDX_W    = $clog2(WIN_SIZE);

    // Sample k of a flattened window occupies [w*k +: w].
    function automatic int unsigned flat_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/pool_window_feeder_if.sv
// ---------------------------------------------------------------------------
// pool_window_feeder_if
// Handshake bundle between the sample stream, the feeder and the pool.
//   s_valid/s_ready/s_data/s_last : serial sample stream into the feeder
//   m_valid/m_ready/m_data/m_last : parallel window out to the pool
//   err                           : sticky framing error from the feeder
// Modports:
//   master : the surrounding system (drives stream, consumes window)
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface pool_window_feeder_if #(
    parameter int unsigned DATA_W   = pool_pkg::DATA_W,
    parameter int unsigned WIN_SIZE = pool_pkg::WIN_SIZE
);

    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_W-1:0]            s_data;
    logic                         s_last;
    logic                         m_valid;
    logic                         m_ready;
    logic [DATA_W*WIN_SIZE-1:0]   m_data;
    logic                         m_last;
    logic                         err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, err
    );

endinterface

// File: rtl/pool_win_bank.sv
// ---------------------------------------------------------------------------
// pool_win_bank
// One window register bank: WIN_SIZE x DATA_W storage plus a small
// EMPTY -> FILLING -> FULL -> EMPTY state machine.
//   clk, rst    : clock, synchronous active-high reset (clears contents too)
//   i_wr_en     : write i_wr_data into slot i_wr_idx this cycle
//   i_wr_idx    : slot index; writing slot WIN_SIZE-1 marks the bank FULL
//   i_wr_data   : sample to store
//   i_release   : consumer has taken the window; FULL -> EMPTY
//   o_full      : bank holds a complete window
//   o_data      : all slots, flattened, slot k at [DATA_W*k +: DATA_W]
// ---------------------------------------------------------------------------
module pool_win_bank
    import pool_pkg::flat_lsb;
#(
    parameter int unsigned DATA_W   = pool_pkg::DATA_W,
    parameter int unsigned WIN_SIZE = pool_pkg::WIN_SIZE,
    localparam int unsigned IDX_W   = $clog2(WIN_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [IDX_W-1:0]           i_wr_idx,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_release,
    output logic                       o_full,
    output logic [DATA_W*WIN_SIZE-1:0] o_data
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mem [WIN_SIZE];
    logic              w_last_slot;

    assign w_last_slot = (i_wr_idx == IDX_W'(WIN_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (i_wr_en) begin
                        r_state <= w_last_slot ? ST_FULL : ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (i_wr_en && w_last_slot) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (i_release) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIN_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_full = (r_state == ST_FULL);

    for (genvar k = 0; k < WIN_SIZE; k++) begin : g_flat
        assign o_data[flat_lsb(k, DATA_W) +: DATA_W] = r_mem[k];
    end

endmodule

// File: rtl/pool_window_feeder.sv
// ---------------------------------------------------------------------------
// pool_window_feeder
// Collects a serial stream of DATA_W samples into ping-pong window banks and
// presents each complete window in parallel to the averaging pool.
//   clk, rst : clock, synchronous active-high reset (the only clear)
//   bus      : pool_window_feeder_if.slave
//              s_valid/s_ready/s_data/s_last : input sample stream
//              m_valid/m_ready/m_data/m_last : window output to the pool
//              err                           : sticky s_last framing error
// NUM_WINDOWS sets how many windows form one feature map (drives m_last).
// ---------------------------------------------------------------------------
module pool_window_feeder #(
    parameter int unsigned DATA_W      = pool_pkg::DATA_W,
    parameter int unsigned WIN_SIZE    = pool_pkg::WIN_SIZE,
    parameter int unsigned NUM_WINDOWS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    pool_window_feeder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(WIN_SIZE);
    localparam int unsigned CNT_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;

    logic                       r_wr_bank;
    logic                       r_rd_bank;
    logic [IDX_W-1:0]           r_wr_idx;
    logic [CNT_W-1:0]           r_win_cnt;
    logic                       r_err;

    logic                       w_full0;
    logic                       w_full1;
    logic [DATA_W*WIN_SIZE-1:0] w_data0;
    logic [DATA_W*WIN_SIZE-1:0] w_data1;
    logic                       w_wr_full;
    logic                       w_s_ready;
    logic                       w_accept;
    logic                       w_m_valid;
    logic                       w_release;
    logic                       w_idx_last;
    logic                       w_cnt_last;

    assign w_wr_full  = r_wr_bank ? w_full1 : w_full0;
    // Gated by rst so nothing is accepted, and s_ready reads low, during reset.
    assign w_s_ready  = !rst && !w_wr_full;
    assign w_accept   = bus.s_valid && w_s_ready;
    assign w_m_valid  = r_rd_bank ? w_full1 : w_full0;
    assign w_release  = w_m_valid && bus.m_ready;
    assign w_idx_last = (r_wr_idx == IDX_W'(WIN_SIZE - 1));
    assign w_cnt_last = (r_win_cnt == CNT_W'(NUM_WINDOWS - 1));

    // Write and release always target different banks when both fire, since
    // the write bank is never full and the read bank always is.
    pool_win_bank #(
        .DATA_W   (DATA_W),
        .WIN_SIZE (WIN_SIZE)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept && !r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.s_data),
        .i_release (w_release && !r_rd_bank),
        .o_full    (w_full0),
        .o_data    (w_data0)
    );

    pool_win_bank #(
        .DATA_W   (DATA_W),
        .WIN_SIZE (WIN_SIZE)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept && r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.s_data),
        .i_release (w_release && r_rd_bank),
        .o_full    (w_full1),
        .o_data    (w_data1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_win_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_idx_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= !r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + IDX_W'(1);
                end
                // Framing stays count-based; s_last is only checked.
                if (bus.s_last != w_idx_last) begin
                    r_err <= 1'b1;
                end
            end
            if (w_release) begin
                r_rd_bank <= !r_rd_bank;
                r_win_cnt <= w_cnt_last ? '0 : r_win_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_rd_bank ? w_data1 : w_data0;
    assign bus.m_last  = w_m_valid && w_cnt_last;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_pool_window_feeder.sv
module tb_pool_window_feeder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pool_window_feeder_if #(.DATA_W(16), .WIN_SIZE(64)) bus ();

    pool_window_feeder #(
        .DATA_W      (16),
        .WIN_SIZE    (64),
        .NUM_WINDOWS (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [15:0] sd;
        logic        sl;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic        e_ml;
        logic        e_err;
        logic [15:0] e_d0;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [15:0] slot(input int k);
        return bus.m_data[16*k +: 16];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nxt, acc, first_drop, drops, npulse, sum;
        logic r;
        int pc [8];
        logic [15:0] pd [8];
        logic pl [8];

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // rst sv sd sl mr | s_ready m_valid m_last err m_data[15:0]
        tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[3] = '{1'b0, 1'b1, 16'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[4] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7};
        tbl[7] = '{1'b1, 1'b1, 16'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[8] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[9] = '{1'b0, 1'b1, 16'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd9};

        for (int i = 0; i < 10; i++) begin
            rst         = tbl[i].rst;
            bus.s_valid = tbl[i].sv;
            bus.s_data  = tbl[i].sd;
            bus.s_last  = tbl[i].sl;
            bus.m_ready = tbl[i].mr;
            tick();
            chk($sformatf("vec%0d s_ready", i), 64'(bus.s_ready), 64'(tbl[i].e_sr));
            chk($sformatf("vec%0d m_valid", i), 64'(bus.m_valid), 64'(tbl[i].e_mv));
            chk($sformatf("vec%0d m_last", i),  64'(bus.m_last),  64'(tbl[i].e_ml));
            chk($sformatf("vec%0d err", i),     64'(bus.err),     64'(tbl[i].e_err));
            chk($sformatf("vec%0d m_data0", i), 64'(slot(0)),     64'(tbl[i].e_d0));
        end
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;

        // Single window 1..64, consumer stalled.
        do_reset();
        chk("A reset m_data zero", 64'(bus.m_data == '0), 64'd1);
        for (int k = 1; k <= 64; k++) begin
            push(16'(k), k == 64);
            if (k == 63) chk("A m_valid before last", 64'(bus.m_valid), 64'd0);
        end
        chk("A m_valid after last", 64'(bus.m_valid), 64'd1);
        chk("A slot0", 64'(slot(0)), 64'd1);
        chk("A slot63", 64'(slot(63)), 64'd64);
        chk("A s_ready other bank", 64'(bus.s_ready), 64'd1);
        chk("A m_last", 64'(bus.m_last), 64'd0);
        chk("A err", 64'(bus.err), 64'd0);
        sum = 0;
        for (int k = 0; k < 64; k++) sum += int'(slot(k));
        chk("A pool_out", 64'(sum >> 6), 64'd32);

        // 192 samples offered with consumer stalled: only two windows fit.
        do_reset();
        nxt = 1; acc = 0; first_drop = -1;
        for (int c = 0; c < 192; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(nxt);
            bus.s_last  = (nxt % 64) == 0;
            r = bus.s_ready;
            if (!r && first_drop < 0) first_drop = c;
            tick();
            if (r) begin nxt++; acc++; end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("B accepted", 64'(acc), 64'd128);
        chk("B first stall cycle", 64'(first_drop), 64'd128);
        chk("B s_ready both full", 64'(bus.s_ready), 64'd0);
        chk("B m_valid", 64'(bus.m_valid), 64'd1);
        chk("B slot0 win1", 64'(slot(0)), 64'd1);
        bus.m_ready = 1'b1;
        #1;
        chk("B s_ready not comb", 64'(bus.s_ready), 64'd0);
        tick();
        bus.m_ready = 1'b0;
        chk("B s_ready after hs", 64'(bus.s_ready), 64'd1);
        chk("B m_valid win2", 64'(bus.m_valid), 64'd1);
        chk("B slot0 win2", 64'(slot(0)), 64'd65);
        chk("B slot63 win2", 64'(slot(63)), 64'd128);
        chk("B m_last win2", 64'(bus.m_last), 64'd0);

        // Continuous stream, consumer always ready: 4 windows, NUM_WINDOWS=3.
        do_reset();
        bus.m_ready = 1'b1;
        drops = 0; npulse = 0;
        for (int c = 0; c < 256; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(c + 1);
            bus.s_last  = ((c + 1) % 64) == 0;
            if (!bus.s_ready) drops++;
            tick();
            if (bus.m_valid) begin
                if (npulse < 8) begin
                    pc[npulse] = c;
                    pd[npulse] = slot(0);
                    pl[npulse] = bus.m_last;
                end
                npulse++;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        chk("C s_ready drops", 64'(drops), 64'd0);
        chk("C pulse count", 64'(npulse), 64'd4);
        for (int w = 0; w < 4; w++) begin
            if (w < npulse) begin
                chk($sformatf("C pulse%0d cycle", w), 64'(pc[w]), 64'(63 + 64 * w));
                chk($sformatf("C pulse%0d slot0", w), 64'(pd[w]), 64'(64 * w + 1));
                chk($sformatf("C pulse%0d m_last", w), 64'(pl[w]), 64'(w == 2));
            end else begin
                chk($sformatf("C pulse%0d missing", w), 64'(npulse), 64'(w + 1));
            end
        end
        chk("C err", 64'(bus.err), 64'd0);

        // Early s_last on sample 10: sticky err, window still completes.
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            push(16'(k), (k == 10) || (k == 64));
            if (k == 9)  chk("D err before", 64'(bus.err), 64'd0);
            if (k == 10) chk("D err set", 64'(bus.err), 64'd1);
            if (k == 40) chk("D err sticky", 64'(bus.err), 64'd1);
        end
        chk("D m_valid", 64'(bus.m_valid), 64'd1);
        chk("D slot63", 64'(slot(63)), 64'd64);
        chk("D err end", 64'(bus.err), 64'd1);

        // Reset mid-window while a full window is held.
        do_reset();
        for (int k = 1; k <= 64; k++) push(16'(k), k == 64);
        for (int k = 65; k <= 94; k++) push(16'(k), k == 69);
        chk("E m_valid before rst", 64'(bus.m_valid), 64'd1);
        chk("E err before rst", 64'(bus.err), 64'd1);
        rst = 1'b1;
        tick();
        chk("E m_valid in rst", 64'(bus.m_valid), 64'd0);
        chk("E s_ready in rst", 64'(bus.s_ready), 64'd0);
        chk("E err in rst", 64'(bus.err), 64'd0);
        chk("E m_data cleared", 64'(bus.m_data == '0), 64'd1);
        rst = 1'b0;
        #1;
        chk("E s_ready after rst", 64'(bus.s_ready), 64'd1);
        for (int k = 0; k < 64; k++) begin
            push(16'h1000 + 16'(k), k == 63);
            if (k == 62) chk("E m_valid early", 64'(bus.m_valid), 64'd0);
        end
        chk("E m_valid fresh", 64'(bus.m_valid), 64'd1);
        chk("E err fresh", 64'(bus.err), 64'd0);
        chk("E m_last fresh", 64'(bus.m_last), 64'd0);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("E slot%0d", k), 64'(slot(k)), 64'(16'h1000 + 16'(k)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
